// File: rtl/param_pkg.sv
// Shared types and field layout for the parameter fetch sequencer.
// Packet order, MSB first: {r0, kb, theta0, k_theta, phi0, k_phi, n_period, q_a, q_d}.
package param_pkg;

    localparam int unsigned FIELD_W = 32;
    localparam int unsigned NPER_W  = 4;
    localparam int unsigned PARAM_W = 260;
    localparam int unsigned IDX_W   = 10;
    localparam int unsigned CNT_W   = 11;
    localparam int unsigned ENTRY_W = PARAM_W + IDX_W;

    localparam int unsigned Q_D_LSB     = 0;
    localparam int unsigned Q_A_LSB     = 32;
    localparam int unsigned NPER_LSB    = 64;
    localparam int unsigned K_PHI_LSB   = 68;
    localparam int unsigned PHI0_LSB    = 100;
    localparam int unsigned K_THETA_LSB = 132;
    localparam int unsigned THETA0_LSB  = 164;
    localparam int unsigned KB_LSB      = 196;
    localparam int unsigned R0_LSB      = 228;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // A word with every force constant zero contributes nothing downstream.
    function automatic logic prm_is_zero(input logic [PARAM_W-1:0] p);
        return (p[KB_LSB      +: FIELD_W] == '0) &&
               (p[K_THETA_LSB +: FIELD_W] == '0) &&
               (p[K_PHI_LSB   +: FIELD_W] == '0) &&
               (p[Q_A_LSB     +: FIELD_W] == '0) &&
               (p[Q_D_LSB     +: FIELD_W] == '0);
    endfunction

endpackage

// File: rtl/param_fifo.sv
// Synchronous FIFO with occupancy output; DEPTH must be a power of two.
// Push and pop in the same cycle on a full FIFO is accepted.
module param_fifo #(
    parameter int unsigned WIDTH = 270,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (occ != '0);
        do_push = push && ((occ != FULL) || do_pop);
    end

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/param_fetch_sequencer.sv
// Walks the parameter RAM 0..n_atoms-1 and streams packets with credit-based issue.
// Optional build macro PARAM_SKIP_ZERO_EN drops returned words whose force constants are all zero.
module param_fetch_sequencer
    import param_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [10:0]         n_atoms,
    output logic [9:0]          ram_addr,
    input  logic signed [31:0]  r0_in,
    input  logic signed [31:0]  kb_in,
    input  logic signed [31:0]  theta0_in,
    input  logic signed [31:0]  k_theta_in,
    input  logic signed [31:0]  phi0_in,
    input  logic signed [31:0]  k_phi_in,
    input  logic [3:0]          n_period_in,
    input  logic signed [31:0]  q_a_in,
    input  logic signed [31:0]  q_d_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [259:0]        out_prm,
    output logic [9:0]          out_idx,
    output logic                busy,
    output logic                done,
    output logic [10:0]         n_emitted
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    state_t               state;
    state_t               state_n;
    logic [CNT_W-1:0]     issue_idx;
    logic [CNT_W-1:0]     n_lat;
    logic                 rd_pend;
    logic [IDX_W-1:0]     idx_pend;
    logic [PARAM_W-1:0]   prm_in;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic [OCC_W-1:0]     occ;
    logic [OCC_W:0]       used;
    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 accept;
    logic                 drained;

    assign prm_in = {r0_in, kb_in, theta0_in, k_theta_in, phi0_in, k_phi_in,
                     n_period_in, q_a_in, q_d_in};

`ifdef PARAM_SKIP_ZERO_EN
    assign push = rd_pend && !prm_is_zero(prm_in);
`else
    assign push = rd_pend;
`endif

    assign out_valid = (occ != '0);
    assign pop       = out_valid && out_ready;
    assign out_idx   = fifo_dout[ENTRY_W-1 -: IDX_W];
    assign out_prm   = fifo_dout[PARAM_W-1:0];
    assign ram_addr  = issue_idx[IDX_W-1:0];

    // Entries held or about to land after this cycle's pop; also zero exactly when the run has drained.
    assign used = {1'b0, occ} + {{OCC_W{1'b0}}, rd_pend} - {{OCC_W{1'b0}}, pop};

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        accept  = 1'b0;
        drained = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (n_atoms != '0) begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (used < (OCC_W+1)'(DEPTH)) begin
                    issue = 1'b1;
                    if (issue_idx == n_lat - CNT_W'(1)) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (used == '0) begin
                    drained = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_idx <= '0;
            n_lat     <= '0;
            rd_pend   <= 1'b0;
            idx_pend  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            n_emitted <= '0;
        end else begin
            state    <= state_n;
            rd_pend  <= issue;
            idx_pend <= issue_idx[IDX_W-1:0];
            done     <= (accept && (n_atoms == '0)) || drained;
            busy     <= (state_n != IDLE) || drained;
            if (accept) begin
                n_lat     <= n_atoms;
                issue_idx <= '0;
            end else if (issue) begin
                issue_idx <= issue_idx + 1'b1;
            end
            if (accept) begin
                n_emitted <= '0;
            end else if (pop) begin
                n_emitted <= n_emitted + 1'b1;
            end
        end
    end

    param_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({idx_pend, prm_in}),
        .pop   (pop),
        .dout  (fifo_dout),
        .occ   (occ)
    );

endmodule

// File: tb/tb_param_fetch_sequencer.sv
// Scoreboard bench for param_fetch_sequencer: a RAM model, queued expected packets
// and a negedge monitor that compares every presented packet and each done pulse.
module tb_param_fetch_sequencer;

    localparam int DEPTH = 4;
    typedef logic [271:0] v_t;

    typedef struct {
        logic [9:0]   idx;
        logic [259:0] prm;
        int           cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [10:0]        n_atoms = '0;
    logic [9:0]         ram_addr;
    logic signed [31:0] r0_in, kb_in, theta0_in, k_theta_in, phi0_in, k_phi_in, q_a_in, q_d_in;
    logic [3:0]         n_period_in;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [259:0]       out_prm;
    logic [9:0]         out_idx;
    logic               busy;
    logic               done;
    logic [10:0]        n_emitted;

    logic signed [31:0] m_r0 [1024], m_kb [1024], m_th0 [1024], m_kth [1024];
    logic signed [31:0] m_phi0 [1024], m_kphi [1024], m_qa [1024], m_qd [1024];
    logic [3:0]         m_np [1024];

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   base = 0;
    int   first_valid_cyc = -1;
    int   done_cyc = -1;
    int   done_cnt = 0;
    int   exp_emit = 0;
    bit   exp_busy = 1'b0;
    bit   done_seen = 1'b0;

    param_fetch_sequencer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .n_atoms     (n_atoms),
        .ram_addr    (ram_addr),
        .r0_in       (r0_in),
        .kb_in       (kb_in),
        .theta0_in   (theta0_in),
        .k_theta_in  (k_theta_in),
        .phi0_in     (phi0_in),
        .k_phi_in    (k_phi_in),
        .n_period_in (n_period_in),
        .q_a_in      (q_a_in),
        .q_d_in      (q_d_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_prm     (out_prm),
        .out_idx     (out_idx),
        .busy        (busy),
        .done        (done),
        .n_emitted   (n_emitted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Parameter RAM: always reads, one-cycle latency.
    always @(posedge clk) begin
        r0_in       <= m_r0[ram_addr];
        kb_in       <= m_kb[ram_addr];
        theta0_in   <= m_th0[ram_addr];
        k_theta_in  <= m_kth[ram_addr];
        phi0_in     <= m_phi0[ram_addr];
        k_phi_in    <= m_kphi[ram_addr];
        n_period_in <= m_np[ram_addr];
        q_a_in      <= m_qa[ram_addr];
        q_d_in      <= m_qd[ram_addr];
    end

    task automatic chk(input string nm, input v_t act, input v_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [259:0] model_prm(input int i);
        return {m_r0[i], m_kb[i], m_th0[i], m_kth[i], m_phi0[i], m_kphi[i], m_np[i], m_qa[i], m_qd[i]};
    endfunction

    function automatic bit model_skipped(input int i);
`ifdef PARAM_SKIP_ZERO_EN
        return (m_kb[i] == 0) && (m_kth[i] == 0) && (m_kphi[i] == 0) && (m_qa[i] == 0) && (m_qd[i] == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic fill_ram(input int n);
        for (int i = 0; i < n; i++) begin
            m_r0[i]   = $urandom;
            m_kb[i]   = $urandom;
            m_th0[i]  = $urandom;
            m_kth[i]  = $urandom;
            m_phi0[i] = $urandom;
            m_kphi[i] = $urandom;
            m_np[i]   = 4'($urandom_range(0, 15));
            m_qa[i]   = $urandom;
            m_qd[i]   = $urandom | 32'd1;
        end
    endtask

    // Pulses start for one edge (E0); returns #1 into cycle 1 with the scoreboard loaded.
    task automatic do_start(input int n, input bit timed);
        exp_t e;
        int   k;
        @(posedge clk); #1;
        start     = 1'b1;
        n_atoms   = 11'(n);
        done_seen = 1'b0;
        first_valid_cyc = -1;
        @(posedge clk); #1;
        start = 1'b0;
        base  = cyc;
        k     = 0;
        for (int i = 0; i < n; i++) begin
            if (!model_skipped(i)) begin
                e.idx = 10'(i);
                e.prm = model_prm(i);
                e.cyc = timed ? base + 2 + k : -1;
                exp_q.push_back(e);
                k++;
            end
        end
        exp_emit = k;
        exp_busy = (n != 0);
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        for (int k = 0; k < budget && !done_seen; k++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        if (!done_seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ram_addr", v_t'(ram_addr), v_t'(0));
        chk("rst_out_valid", v_t'(out_valid), v_t'(0));
        chk("rst_out_prm", v_t'(out_prm), v_t'(0));
        chk("rst_out_idx", v_t'(out_idx), v_t'(0));
        chk("rst_busy", v_t'(busy), v_t'(0));
        chk("rst_done", v_t'(done), v_t'(0));
        chk("rst_n_emitted", v_t'(n_emitted), v_t'(0));
    endtask

    // Monitor: every presented packet must equal the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_packet_idx", v_t'(out_idx), v_t'(1024));
                end else begin
                    chk("pkt_idx", v_t'(out_idx), v_t'(exp_q[0].idx));
                    chk("pkt_prm", v_t'(out_prm), v_t'(exp_q[0].prm));
                    if (out_ready) begin
                        if (exp_q[0].cyc >= 0) chk("pkt_cycle", v_t'(cyc), v_t'(exp_q[0].cyc));
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_seen = 1'b1;
                chk("done_n_emitted", v_t'(n_emitted), v_t'(exp_emit));
                chk("done_queue_left", v_t'(exp_q.size()), v_t'(0));
                chk("done_busy", v_t'(busy), v_t'(exp_busy));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        fill_ram(1024);
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Five packets back to back, cycles 3..7, done at cycle 8.
        fill_ram(5);
        for (int i = 0; i < 5; i++) m_r0[i] = i + 1;
        do_start(5, 1'b1);
        wait_done(50, 1'b0);
        chk("t1_first_valid_cycle", v_t'(first_valid_cyc), v_t'(base + 2));
        chk("t1_done_cycle", v_t'(done_cyc), v_t'(base + 7));

        // Back-pressure during cycles 3..10; issue must stall at DEPTH.
        fill_ram(8);
        do_start(8, 1'b0);
        for (int j = 1; j <= 12; j++) begin
            out_ready = !(j >= 3 && j <= 10);
            if (j == 10) chk("t2_stall_addr", v_t'(ram_addr), v_t'(DEPTH));
            @(posedge clk); #1;
        end
        wait_done(50, 1'b0);

        // Empty window: done next cycle, nothing else moves.
        do_start(0, 1'b0);
        chk("t3_done", v_t'(done), v_t'(1));
        chk("t3_busy", v_t'(busy), v_t'(0));
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk("t3_done_after", v_t'(done), v_t'(0));
            chk("t3_busy_after", v_t'(busy), v_t'(0));
            chk("t3_valid", v_t'(out_valid), v_t'(0));
        end

        // Restart attempt ignored, then reset in cycle 4 abandons the run.
        fill_ram(10);
        do_start(10, 1'b0);
        @(posedge clk); #1;
        start   = 1'b1;
        n_atoms = 11'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4_addr_after_ignored_start", v_t'(ram_addr), v_t'(2));
        chk("t4_busy", v_t'(busy), v_t'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        chk_reset_vals();
        @(posedge clk); #1;
        chk_reset_vals();
        rst_n = 1'b1;
        fill_ram(3);
        do_start(3, 1'b1);
        wait_done(50, 1'b0);

        // Full RAM with random back-pressure; done exactly once.
        fill_ram(1024);
        dc = done_cnt;
        do_start(1024, 1'b0);
        wait_done(20000, 1'b1);
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
        end
        chk("t5_done_once", v_t'(done_cnt), v_t'(dc + 1));

        // Indices 1 and 3 carry all-zero force constants.
        fill_ram(4);
        for (int i = 1; i < 4; i += 2) begin
            m_r0[i] = 7;
            m_kb[i] = 0; m_kth[i] = 0; m_kphi[i] = 0; m_qa[i] = 0; m_qd[i] = 0;
        end
        do_start(4, 1'b0);
        wait_done(50, 1'b0);
`ifdef PARAM_SKIP_ZERO_EN
        chk("t6_n_emitted", v_t'(n_emitted), v_t'(2));
`else
        chk("t6_n_emitted", v_t'(n_emitted), v_t'(4));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_fetch_sequencer.md
# param_fetch_sequencer

Walks the force-field parameter RAM from index 0 to `n_atoms-1` and turns its free-running one-cycle synchronous read into a valid/ready stream of parameter packets for the bonded/electrostatic force pipeline. It sits between the scan controller, which supplies `start` and `n_atoms`, and the force datapath. It owns the RAM address, tracks reads in flight, and buffers returned words so that downstream back-pressure never loses data.

## Interface
- `DEPTH`, 4: output FIFO entries (≥3 for full throughput; power of two).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; accepted only in IDLE.
- `n_atoms` in 11: window count, 0..1024; sampled with `start`.
- `ram_addr` out 10: address to parameter RAM.
- `r0_in`, `kb_in`, `theta0_in`, `k_theta_in`, `phi0_in`, `k_phi_in`, `q_a_in`, `q_d_in` in 32 each (signed): RAM data outputs.
- `n_period_in` in 4: RAM periodicity output.
- `out_valid` out 1: packet available.
- `out_ready` in 1: consumer accepts.
- `out_prm` out 260: packed {r0, kb, theta0, k_theta, phi0, k_phi, n_period, q_a, q_d}, MSB first.
- `out_idx` out 10: RAM index of the packet.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle completion pulse.
- `n_emitted` out 11: packets handed off in the current or last run.

## Operation
- FSM: IDLE -> RUN on `start`. RUN -> DRAIN when the last index has been issued. DRAIN -> IDLE when no read is in flight, the FIFO is empty and the final handshake has completed; `done` pulses on that transition.
- If `start` arrives with `n_atoms==0`, the FSM goes IDLE -> IDLE, `done` pulses the next cycle, and no packets are produced. `start` is ignored while `busy`.
- Issue: in RUN, `ram_addr` = `issue_idx`. A read is issued in a cycle when `occ + inflight - pop < DEPTH`, where `pop` = `out_valid & out_ready`. On issue, `issue_idx` increments.
- `ram_addr` holds its value whenever no issue occurs, including in IDLE. Since the RAM always reads, no enable is needed.
- Return: a read issued in cycle k has its data on the `*_in` ports in cycle k+1. The data is pushed at the end of cycle k+1, tagged with its index, which is delayed alongside it.
- Packets leave in index order. Each handshake increments `n_emitted`; `start` clears it to 0.
- Simultaneous push and pop on a full FIFO is legal. Occupancy is unchanged in that case.
- The credit rule guarantees that a push never overflows the FIFO. `out_prm` and `out_idx` are stable while `out_valid` is high and `out_ready` is low.
- Reset mid-run abandons the run: all state is cleared and any in-flight returns are discarded.

## Timing
- Reset values: `ram_addr`=0, `out_valid`=0, `out_prm`=0, `out_idx`=0, `busy`=0, `done`=0, `n_emitted`=0.
- `start` sampled at edge E0. RUN and issue of index 0 occur in cycle 1. Data is on the ports in cycle 2. `out_valid` first goes high in cycle 3.
- With `out_ready` held at 1: one packet per cycle, and `done` arrives n_atoms+3 cycles after E0.
- `busy` is high from the cycle after `start` is accepted through the cycle `done` is high.

## Configuration
- `PARAM_SKIP_ZERO_EN` defined: a returned word whose `kb`, `k_theta`, `k_phi`, `q_a` and `q_d` are all zero is not pushed. It does not occupy a FIFO entry or count in `n_emitted`, and its credit is released on the return cycle. `done` still fires only after all `n_atoms` reads have returned.
- `PARAM_SKIP_ZERO_EN` undefined: every index is emitted, so `n_emitted` equals `n_atoms` at `done`.

## Structure
- Shared package `param_pkg` holds:
  - the field width constants (32 and 4) and `PARAM_W`=260;
  - bit-slice localparams for each field in the packed order;
  - the FSM state enum {IDLE, RUN, DRAIN}.
- Sub-module `param_fifo` is a synchronous FIFO of width 270 and depth `DEPTH`, with an occupancy output. The top level holds the FSM, the credit counter and the index pipeline.

## Test plan
- `n_atoms`=5, `out_ready`=1, RAM index i holding r0=i+1 -> 5 packets, idx 0..4, r0 1..5, on consecutive cycles 3..7; `done` at cycle 8; `n_emitted`=5.
- `n_atoms`=8, `out_ready` low for cycles 3..10 -> `ram_addr` stalls at `DEPTH`; no packet is lost or duplicated; `out_prm` is stable while stalled; idx order is 0..7.
- `n_atoms`=0 -> `done` the next cycle, `out_valid` never high, `busy` stays 0.
- `start` pulsed again mid-run, then `rst_n` asserted in cycle 4 of a 10-entry run -> the second `start` is ignored; after reset all outputs are at reset values; a fresh `start` restarts at idx 0.
- `n_atoms`=1024 with random `out_ready` -> final idx 1023; `ram_addr` never exceeds 1023; `done` fires once.
- `PARAM_SKIP_ZERO_EN`, indices 1 and 3 of 4 all-zero -> only idx 0 and 2 are emitted; `n_emitted`=2; `done` still pulses.
